// File: rtl/bin2aiken_seq.sv
// Serial binary-to-decimal converter: double-dabble shift engine followed by a
// per-digit code map producing Aiken 2421 (mode=0) or plain 8421 BCD (mode=1).
module bin2aiken_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      bin_in,
    input  logic                  mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   aiken_out,
    output logic                  overflow,
    output logic                  busy
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    localparam logic [63:0] MAXDEC  = pow10(DIGITS) - 64'd1;
    localparam logic [63:0] MAXBIN  = (64'd1 << WIDTH) - 64'd1;
    localparam bit          CAN_OVF = (MAXBIN > MAXDEC);

    // Double-dabble correction: any digit >= 5 gets +3 before the shift.
    function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
        logic [BW-1:0] r;
        logic [3:0]    d;
        r = b;
        for (int k = 0; k < DIGITS; k++) begin
            d = b[4*k +: 4];
            if (d >= 4'd5) r[4*k +: 4] = d + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [3:0] map_digit(input logic [3:0] d, input logic m);
        logic [3:0] c;
        c = d;
        if (!m) begin
            case (d)
                4'd5:    c = 4'b1011;
                4'd6:    c = 4'b1100;
                4'd7:    c = 4'b1101;
                4'd8:    c = 4'b1110;
                4'd9:    c = 4'b1111;
                default: c = d;
            endcase
        end
        return c;
    endfunction

    function automatic logic [BW-1:0] map_all(input logic [BW-1:0] b, input logic m);
        logic [BW-1:0] r;
        r = '0;
        for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = map_digit(b[4*k +: 4], m);
        return r;
    endfunction

    typedef enum logic [1:0] {IDLE, SHIFT, MAP, DONE} state_t;

    state_t                state, state_nxt;
    logic [WIDTH-1:0]      bin_sr;
    logic [BW-1:0]         bcd;
    logic [BW-1:0]         bcd_adj;
    logic [BW+WIDTH-1:0]   sr_nxt;
    logic [CW-1:0]         cnt;
    logic                  mode_r;
    logic                  ovf_r;
    logic                  ovf_in;

    assign ovf_in  = CAN_OVF && ({{(64-WIDTH){1'b0}}, bin_in} > MAXDEC);
    assign bcd_adj = add3(bcd);
    assign sr_nxt  = {bcd_adj, bin_sr} << 1;

    assign in_ready  = (state == IDLE);
    assign busy      = (state == SHIFT) || (state == MAP);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = SHIFT;
            SHIFT:   if (cnt == CW'(1)) state_nxt = MAP;
            MAP:     state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_sr    <= '0;
            bcd       <= '0;
            cnt       <= '0;
            mode_r    <= 1'b0;
            ovf_r     <= 1'b0;
            aiken_out <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin_sr <= bin_in;
                        mode_r <= mode;
                        ovf_r  <= ovf_in;
                        bcd    <= '0;
                        cnt    <= CW'(WIDTH);
                    end
                end
                SHIFT: begin
                    bcd    <= sr_nxt[BW+WIDTH-1:WIDTH];
                    bin_sr <= sr_nxt[WIDTH-1:0];
                    cnt    <= cnt - CW'(1);
                end
                MAP: begin
                    // Out-of-range words report zero digits; carries lost from the top digit are hidden here.
                    aiken_out <= ovf_r ? '0 : map_all(bcd, mode_r);
                    overflow  <= ovf_r;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2aiken_seq.sv
// Bench for bin2aiken_seq: default instance (8-bit, 3 digits) and a 2-digit
// instance for range-overflow cases, checked against a division-based model.
module tb_bin2aiken_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, mode, out_valid, out_ready, overflow, busy;
    logic [7:0]  bin_in;
    logic [11:0] aiken_out;

    logic        in_valid2, in_ready2, mode2, out_valid2, out_ready2, overflow2, busy2;
    logic [7:0]  bin_in2;
    logic [7:0]  aiken_out2;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    bin2aiken_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .bin_in(bin_in), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .aiken_out(aiken_out), .overflow(overflow), .busy(busy)
    );

    bin2aiken_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .bin_in(bin_in2), .mode(mode2), .out_valid(out_valid2), .out_ready(out_ready2),
        .aiken_out(aiken_out2), .overflow(overflow2), .busy(busy2)
    );

    // Reference: decimal digits by repeated division, Aiken by adding 6 to digits 5..9.
    function automatic logic [40:0] ref_conv(input longint unsigned v, input bit m, input int nd);
        longint unsigned lim, x;
        logic [39:0]     code;
        logic [3:0]      d;
        lim  = 1;
        code = '0;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        if (v >= lim) return {1'b1, 40'd0};
        x = v;
        for (int k = 0; k < nd; k++) begin
            d = 4'(x % 10);
            x = x / 10;
            code[4*k +: 4] = (m || d < 4'd5) ? d : d + 4'd6;
        end
        return {1'b0, code};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            n_cmp++;
            if ((in_ready && out_valid) || (in_ready2 && out_valid2)) begin
                n_fail++;
                $display("FAIL handshake_excl: in_ready=%0b out_valid=%0b in_ready2=%0b out_valid2=%0b, required not both high",
                         in_ready, out_valid, in_ready2, out_valid2);
            end
        end
    end

    task automatic run1(input logic [7:0] b, input logic m, output int lat);
        int w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin @(negedge clk); w++; end
        in_valid = 1'b1; bin_in = b; mode = m;
        @(posedge clk); #1;
        in_valid = 1'b0; bin_in = 8'($urandom); mode = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic ack1();
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic run2(input logic [7:0] b, input logic m, output int lat);
        int w = 0;
        @(negedge clk);
        while (!in_ready2 && w < 50) begin @(negedge clk); w++; end
        in_valid2 = 1'b1; bin_in2 = b; mode2 = m;
        @(posedge clk); #1;
        in_valid2 = 1'b0; bin_in2 = 8'($urandom); mode2 = 1'($urandom);
        lat = 0;
        while (!out_valid2 && lat < 50) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic ack2();
        @(negedge clk); out_ready2 = 1'b1;
        @(posedge clk); #1; out_ready2 = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] got;
        got = {in_ready, out_valid, overflow, busy, |aiken_out};
        n_cmp++;
        if (got !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_state: {in_ready,out_valid,overflow,busy,|aiken}=%b, required 10000", got);
        end
        got = {in_ready2, out_valid2, overflow2, busy2, |aiken_out2};
        n_cmp++;
        if (got !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_state2: {in_ready,out_valid,overflow,busy,|aiken}=%b, required 10000", got);
        end
    endtask

    task automatic test_basic();
        logic [7:0] vals[8];
        logic       mods[8];
        logic [40:0] e;
        int lat;
        vals = '{8'd59, 8'd59, 8'd255, 8'd0, 8'd0, 8'($urandom), 8'($urandom), 8'($urandom)};
        mods = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom)};
        for (int i = 0; i < 8; i++) begin
            run1(vals[i], mods[i], lat);
            e = ref_conv(vals[i], mods[i], 3);
            n_cmp++;
            if (lat !== 9) begin
                n_fail++;
                $display("FAIL basic_latency: value %0d latency %0d, required 9", vals[i], lat);
            end
            n_cmp++;
            if ({overflow, aiken_out} !== {e[40], e[11:0]}) begin
                n_fail++;
                $display("FAIL basic_code: value %0d mode %0b got ovf=%0b code=%h, required ovf=%0b code=%h",
                         vals[i], mods[i], overflow, aiken_out, e[40], e[11:0]);
            end
            if (i == 0) begin
                n_cmp++;
                if (aiken_out !== 12'b0000_1011_1111) begin
                    n_fail++;
                    $display("FAIL basic_59_aiken: got %b, required 000010111111", aiken_out);
                end
            end
            ack1();
        end
    endtask

    task automatic test_overflow();
        logic [7:0] vals[12];
        logic [40:0] e;
        int lat;
        vals[0] = 8'd100; vals[1] = 8'd99; vals[2] = 8'd255; vals[3] = 8'd0;
        for (int i = 4; i < 12; i++) vals[i] = 8'($urandom);
        for (int i = 0; i < 12; i++) begin
            logic m;
            m = (i == 1) ? 1'b0 : 1'($urandom);
            run2(vals[i], m, lat);
            e = ref_conv(vals[i], m, 2);
            n_cmp++;
            if (lat !== 9 || {overflow2, aiken_out2} !== {e[40], e[7:0]}) begin
                n_fail++;
                $display("FAIL ovf_code: value %0d mode %0b lat=%0d ovf=%0b code=%h, required lat=9 ovf=%0b code=%h",
                         vals[i], m, lat, overflow2, aiken_out2, e[40], e[7:0]);
            end
            ack2();
        end
    endtask

    task automatic test_backpressure();
        logic [40:0] e;
        int lat;
        run1(8'd123, 1'b0, lat);
        e = ref_conv(123, 1'b0, 3);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'b1; bin_in = 8'($urandom);
            n_cmp++;
            if ({out_valid, in_ready, busy, aiken_out} !== {3'b100, e[11:0]}) begin
                n_fail++;
                $display("FAIL stall_hold: cycle %0d out_valid=%0b in_ready=%0b busy=%0b code=%h, required 1 0 0 %h",
                         i, out_valid, in_ready, busy, aiken_out, e[11:0]);
            end
        end
        in_valid = 1'b0;
        ack1();
        n_cmp++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL stall_release: in_ready=%0b out_valid=%0b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        @(negedge clk);
        in_valid = 1'b1; bin_in = 8'd200; mode = 1'b0;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy: busy=%0b, required 1", busy);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, overflow, busy, aiken_out} !== {4'b1000, 12'h000}) begin
            n_fail++;
            $display("FAIL mid_reset: in_ready=%0b out_valid=%0b ovf=%0b busy=%0b code=%h, required 1 0 0 0 000",
                     in_ready, out_valid, overflow, busy, aiken_out);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_no_output: cycle %0d out_valid=%0b, required 0", i, out_valid);
            end
        end
        run1(8'd37, 1'b0, lat);
        n_cmp++;
        if (lat !== 9 || aiken_out !== 12'b0000_0011_1101 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_after_37: lat=%0d code=%b ovf=%0b, required lat=9 code=000000111101 ovf=0",
                     lat, aiken_out, overflow);
        end
        ack1();
    endtask

    task automatic test_back_to_back();
        int prev, acc, w;
        logic [7:0] b;
        logic m;
        logic [40:0] e;
        prev = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom); m = 1'($urandom);
            e = ref_conv(b, m, 3);
            w = 0;
            @(negedge clk);
            while (!in_ready && w < 50) begin @(negedge clk); w++; end
            in_valid = 1'b1; bin_in = b; mode = m;
            @(posedge clk); #1;
            acc = cyc;
            in_valid = 1'b0;
            if (i > 0) begin
                n_cmp++;
                if (acc - prev !== 11) begin
                    n_fail++;
                    $display("FAIL b2b_interval: word %0d interval %0d cycles, required 11", i, acc - prev);
                end
            end
            prev = acc;
            w = 0;
            @(negedge clk);
            while (!out_valid && w < 50) begin @(negedge clk); w++; end
            n_cmp++;
            if ({out_valid, overflow, aiken_out} !== {1'b1, e[40], e[11:0]}) begin
                n_fail++;
                $display("FAIL b2b_code: value %0d mode %0b valid=%0b ovf=%0b code=%h, required 1 %0b %h",
                         b, m, out_valid, overflow, aiken_out, e[40], e[11:0]);
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_sweep();
        logic [40:0] e;
        logic first_m;
        int lat, stall;
        for (int v = 0; v < 256; v++) begin
            first_m = 1'($urandom);
            for (int j = 0; j < 2; j++) begin
                logic m;
                m = first_m ^ 1'(j);
                run1(8'(v), m, lat);
                e = ref_conv(v, m, 3);
                n_cmp++;
                if (lat !== 9 || {overflow, aiken_out} !== {e[40], e[11:0]}) begin
                    n_fail++;
                    $display("FAIL sweep: value %0d mode %0b lat=%0d ovf=%0b code=%h, required lat=9 ovf=%0b code=%h",
                             v, m, lat, overflow, aiken_out, e[40], e[11:0]);
                end
                stall = $urandom_range(0, 3);
                repeat (stall) @(posedge clk);
                ack1();
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; bin_in = '0; mode = 1'b0; out_ready = 1'b0;
        in_valid2 = 1'b0; bin_in2 = '0; mode2 = 1'b0; out_ready2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
